// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared types, constants and helpers for the score BCD converter
package score_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_t;

  // 64-bit result so that ten digits (10^10 - 1) still fits
  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble nibble correction: values of 5 or more get +3
module bcd_add3
  import score_pkg::*;
(
  input  bcd_digit_t nib_i,
  output bcd_digit_t nib_o
);

  assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;

endmodule

// File: rtl/score_bcd_converter.sv
// rtl/score_bcd_converter.sv - iterative binary-to-BCD score converter with saturation
// Optional leading-zero blanking when SCORE_BCD_BLANK_EN is defined.
module score_bcd_converter
  import score_pkg::*;
#(
  parameter int IN_W   = 14,
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IN_W-1:0]     score_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] digits,
  output logic                overflow
);

  localparam int              BCD_W   = 4 * DIGITS;
  localparam int              CNT_W   = 6;
  localparam longint unsigned MAX_VAL = pow10(DIGITS) - 64'd1;
  // When every IN_W-bit value fits in DIGITS digits the compare folds to 0
  localparam bit              CAN_OVF = ((64'd1 << IN_W) - 64'd1) > MAX_VAL;

  conv_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IN_W-1:0]  shift_q, shift_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [BCD_W-1:0] bcd_adj, bcd_next, result;
  logic [BCD_W-1:0] digits_q, digits_d;
  logic             ovf_q, ovf_d;
  logic             overflow_q, overflow_d;
  logic             accept, last_shift;

  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nib_i (bcd_q[4*g +: 4]),
      .nib_o (bcd_adj[4*g +: 4])
    );
  end

  assign accept     = (state_q == IDLE) && in_valid && !clear;
  assign last_shift = (state_q == SHIFT) && (cnt_q == CNT_W'(1));
  assign bcd_next   = {bcd_adj[BCD_W-2:0], shift_q[IN_W-1]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (in_valid) state_d = SHIFT;
        SHIFT:   if (cnt_q == CNT_W'(1)) state_d = DONE;
        DONE:    if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  // Final digit pattern captured on the edge that enters DONE
  always_comb begin
    result = bcd_next;
`ifdef SCORE_BCD_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (bcd_next[4*i +: 4] != 4'd0) lead = 1'b0;
        if (lead) result[4*i +: 4] = BLANK_CODE;
      end
    end
`endif
    if (ovf_q) result = {DIGITS{4'h9}};
  end

  always_comb begin
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    digits_d   = digits_q;
    overflow_d = overflow_q;
    if (clear) begin
      cnt_d      = '0;
      digits_d   = '0;
      overflow_d = 1'b0;
    end else if (accept) begin
      shift_d = score_in;
      bcd_d   = '0;
      cnt_d   = CNT_W'(IN_W);
      ovf_d   = CAN_OVF && (64'(score_in) > MAX_VAL);
    end else if (state_q == SHIFT) begin
      shift_d = shift_q << 1;
      bcd_d   = bcd_next;
      cnt_d   = cnt_q - CNT_W'(1);
      if (last_shift) begin
        digits_d   = result;
        overflow_d = ovf_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      shift_q    <= '0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      digits_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      digits_q   <= digits_d;
      overflow_q <= overflow_d;
    end
  end

  assign digits   = digits_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_score_bcd_converter.sv
// tb/tb_score_bcd_converter.sv - randomized self-checking bench for score_bcd_converter
module tb_score_bcd_converter;

  localparam int IN_W   = 14;
  localparam int DIGITS = 4;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                clear;
  logic                in_valid;
  logic                in_ready;
  logic [IN_W-1:0]     score_in;
  logic                out_valid;
  logic                out_ready;
  logic [4*DIGITS-1:0] digits;
  logic                overflow;

  int n_tests = 0;
  int n_fail  = 0;

  score_bcd_converter #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .score_in  (score_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .digits    (digits),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: decimal digits by division, saturate above 9999, optional blanking
  function automatic logic [15:0] model_digits(input int unsigned s);
    logic [15:0] r;
    int unsigned v;
    bit lead;
    if (s > 9999) return 16'h9999;
    v = s;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
`ifdef SCORE_BCD_BLANK_EN
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (r[4*i +: 4] != 4'd0) lead = 1'b0;
      if (lead) r[4*i +: 4] = 4'hF;
    end
`else
    lead = 1'b0;
`endif
    return r;
  endfunction

  task automatic start(input int unsigned s);
    int n;
    n = 0;
    while (!in_ready && n < 64) begin
      tick();
      n++;
    end
    check("in_ready_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b1;
    score_in = IN_W'(s);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 64) begin
      tick();
      lat++;
      if (lat == 1) check("in_ready_in_shift", 64'(in_ready), 64'd0);
    end
    check("done_timeout", 64'(out_valid), 64'd1);
  endtask

  task automatic run(input int unsigned s, input int hold, input bit noise);
    int lat;
    logic [15:0] exp_d;
    exp_d = model_digits(s);
    start(s);
    wait_done(lat);
    check("latency", 64'(lat), 64'(IN_W));
    check("digits", 64'(digits), 64'(exp_d));
    check("overflow", 64'(overflow), 64'(s > 9999));
    check("in_ready_in_done", 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      if (noise) begin
        in_valid = 1'b1;
        score_in = IN_W'($urandom_range(0, 16383));
      end
      tick();
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_ready", 64'(in_ready), 64'd0);
      check("hold_digits", 64'(digits), 64'(exp_d));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("post_hs_valid", 64'(out_valid), 64'd0);
    check("post_hs_ready", 64'(in_ready), 64'd1);
    check("post_hs_digits", 64'(digits), 64'(exp_d));
  endtask

  initial begin
    int lat;
    int unsigned s;
    reset_n   = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    score_in  = '0;
    tick();
    tick();
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_digits", 64'(digits), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    tick();

    run(1234, 0, 1'b0);
    run(0, 0, 1'b0);
    run(9999, 0, 1'b0);
    run(12000, 0, 1'b0);
    run(5, 0, 1'b0);
    run(10000, 0, 1'b0);
    run(16383, 0, 1'b0);
    run(777, 20, 1'b1);

    // Asynchronous reset in the middle of a conversion
    start(4321);
    repeat (6) tick();
    check("shift_hold_digits", 64'(digits), 64'(model_digits(777)));
    tick();
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_digits", 64'(digits), 64'd0);
    check("async_rst_ovf", 64'(overflow), 64'd0);
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_ready", 64'(in_ready), 64'd1);
    tick();
    reset_n = 1'b1;
    tick();

    // Clear in DONE beats a simultaneous out_ready and in_valid
    start(12000);
    wait_done(lat);
    check("clr_pre_digits", 64'(digits), 64'h9999);
    check("clr_pre_ovf", 64'(overflow), 64'd1);
    clear     = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    score_in  = IN_W'(77);
    tick();
    clear     = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("clr_digits", 64'(digits), 64'd0);
    check("clr_ovf", 64'(overflow), 64'd0);
    check("clr_valid", 64'(out_valid), 64'd0);
    check("clr_ready", 64'(in_ready), 64'd1);
    run(42, 0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0:       s = $urandom_range(9990, 10010);
        1:       s = $urandom_range(0, 99);
        default: s = $urandom_range(0, 16383);
      endcase
      run(s, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/score_bcd_converter.md
Name: score_bcd_converter

Overview:
Sequential, parametrised binary-to-BCD converter for on-screen score display. Iterative shift-and-add-3 (double dabble), one input bit per cycle. Valid/ready handshake on both sides, saturation on overflow, synchronous clear. Sits between game score logic and the digit/sprite renderer; generalises the fixed 14-bit, 4-digit score decoder.

Parameters:
IN_W, 14, width of the binary score input (legal 4..32)
DIGITS, 4, number of BCD output digits (legal 1..10); MAX_VAL = 10^DIGITS - 1

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
clear  input  1  synchronous clear: abort conversion, zero digits, return to IDLE
in_valid  input  1  score_in is valid
in_ready  output  1  converter can accept a score (high only in IDLE)
score_in  input  IN_W  unsigned binary score
out_valid  output  1  digits/overflow hold a completed result
out_ready  input  1  consumer accepts result
digits  output  4*DIGITS  BCD digits, digit 0 (ones) in bits [3:0], most significant digit in top nibble
overflow  output  1  score_in exceeded MAX_VAL; digits saturated

Behaviour:
- One clock; reset is asynchronous and active-low: reset_n low forces state IDLE, digits = 0, overflow = 0, out_valid = 0, bit counter = 0, immediately and regardless of clk.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready = 1. On in_valid && in_ready at an edge: latch score_in into shift reg, clear BCD working reg, load counter = IN_W, latch ovf = (score_in > MAX_VAL), go SHIFT.
- SHIFT: each cycle, every working nibble >= 5 gets +3, then {BCD, shift reg} shifts left by 1 (MSB of score enters BCD bit 0; bits shifted out of top BCD nibble discarded). Counter decrements; after the IN_W-th shift go DONE.
- On the DONE-entry edge, digits register loads the working BCD (or all 9s if ovf) and overflow loads ovf. digits/overflow change only on that edge, on clear, or on reset; they hold the last result in IDLE/SHIFT.
- DONE: out_valid = 1; digits stable. Leave to IDLE on out_ready. A new input is accepted no earlier than the cycle after the output handshake.
- Latency: out_valid rises exactly IN_W cycles after the accepting edge (14 for defaults); throughput one result per IN_W+2 cycles.
- in_valid while not in IDLE is ignored (in_ready = 0); no queuing.
- clear (sync) in any state: next edge -> IDLE, digits = 0, overflow = 0, out_valid = 0. clear wins over a simultaneous in_valid or out_ready.
- If 2^IN_W - 1 <= MAX_VAL, overflow is constant 0 (comparison elaborates away).
- Working BCD register width is exactly 4*DIGITS bits; no internal value exceeds it.

Optional Feature:
Macro SCORE_BCD_BLANK_EN. Defined: on DONE entry, leading zero digits (all zero digits above the most significant non-zero digit) are replaced by BLANK_CODE 4'hF; digit 0 is never blanked (score 0 shows a single 0); saturated results are never blanked. Undefined: digits are plain BCD with leading zeros.

Decomposition:
- Package score_pkg: bcd_digit_t (logic [3:0]), BLANK_CODE = 4'hF, state enum conv_state_t {IDLE, SHIFT, DONE}, function pow10 for MAX_VAL.
- One sub-module: bcd_add3 (combinational nibble adjust: out = in >= 5 ? in + 3 : in), instantiated DIGITS times via generate.

Test Plan:
- Defaults, score_in = 1234, out_ready = 1 -> out_valid exactly 14 cycles after accept, digits = 16'h1234, overflow = 0.
- score_in = 0 then 9999 back-to-back -> 16'h0000 then 16'h9999, second in_ready only after first output handshake.
- score_in = 12000 (> 9999) -> digits = 16'h9999, overflow = 1; next input 5 -> 16'h0005, overflow = 0.
- Backpressure: out_ready = 0 for 20 cycles after out_valid -> digits/out_valid held, in_ready = 0, new in_valid ignored.
- reset_n pulsed low mid-SHIFT (cycle 7), then clear asserted in DONE on a later conversion -> all outputs 0 and IDLE immediately / next edge; following conversion of 42 -> 16'h0042.
- SCORE_BCD_BLANK_EN defined: 42 -> 16'hFF42; 0 -> 16'hFFF0; 12000 -> 16'h9999; IN_W = 20, DIGITS = 6: 999999 -> 24'h999999.
